sparrow_regfile_sb: RTL
=======================

// Module: sparrow_regfile_sb
// PURPOSE
//  Parametrised integer register file: NRD read ports, NWR write ports, optional
//  write-to-read bypass, per-register busy scoreboard. Next-generation regfile for
//  the sparrow core; lets decode stall on RAW hazards and supports dual writeback.
// PARAMETERS
//  XLEN     32  data width of each register
//  NREGS    32  number of architectural registers, power of two, >= 2
//  NRD      2   number of read ports, >= 1
//  NWR      2   number of write ports, >= 1
//  BYPASS   1   1: a read sees same-cycle write data; 0: it sees the registered value
//  ZERO_REG 1   1: register 0 is hardwired to zero, never written, never busy
// PORTS  (AW = $clog2(NREGS))
//  clk           in   1             clock, all state updates on rising edge
//  reset         in   1             synchronous, active-high reset
//  rd_addr_i     in   NRD x AW      read addresses
//  rd_data_o     out  NRD x XLEN    read data, combinational
//  rd_busy_o     out  NRD x 1       busy bit of the addressed register, combinational
//  wr_en_i       in   NWR x 1       write enables
//  wr_addr_i     in   NWR x AW      write addresses
//  wr_data_i     in   NWR x XLEN    write data
//  alloc_en_i    in   1             mark alloc_addr_i busy (new producer issued)
//  alloc_addr_i  in   AW            register being allocated
//  flush_i       in   1             clear every busy bit (pipeline flush)
//  busy_o        out  NREGS         full scoreboard vector, registered
// BEHAVIOUR
//  - Reset (sync, high): all registers <= 0, all busy bits <= 0; reset beats every
//    other input in that cycle. After reset rd_data_o = 0, rd_busy_o = 0, busy_o = 0.
//  - Write: reg[a] <= data on the edge after wr_en. Latency 1 cycle to the array.
//  - Write conflict (two ports, same addr, same cycle): highest port index wins.
//  - ZERO_REG=1: writes and allocs to addr 0 ignored; reads of 0 return 0 and
//    not-busy regardless of BYPASS.
//  - Read, BYPASS=1: if any enabled write port targets rd_addr this cycle, rd_data
//    = that write data (highest index wins), else reg[rd_addr]. BYPASS=0: always
//    reg[rd_addr]. rd_busy always reflects registered busy (no bypass on busy).
//  - Scoreboard, next-state per register r, priority high to low:
//      flush_i                         -> 0
//      alloc_en_i & alloc_addr_i==r    -> 1   (new producer beats same-cycle write)
//      any wr_en_i & wr_addr_i==r      -> 0
//      otherwise                       -> hold
//  - Flush does not affect data writes in the same cycle; alloc in a flush cycle is
//    dropped.
//  - Write to a non-busy register is legal (data written, busy stays 0).
//  - No handshake/backpressure: every enabled write is accepted in its cycle.
// STRUCTURE
//  - sparrow_pkg: REG_AW localparam helper, typedef reg_addr_t / xlen_t for the
//    default config; modules keep local AW for non-default params.
//  - One sub-module, sparrow_regfile_wsel: given wr_en/wr_addr/wr_data and one
//    address, returns hit + winning data (highest index). Instanced per register
//    (write decode) and per read port (bypass).
//  - Register and busy arrays in generate loops; index 0 tied off when ZERO_REG=1.
// TESTING
//  1 reset with random inputs active -> all rd_data_o=0, busy_o=0 next cycle.
//  2 wr p0 x5=0xDEADBEEF; next cycle rd p1 x5 -> 0xDEADBEEF; same-cycle rd with
//    BYPASS=1 -> 0xDEADBEEF, BYPASS=0 -> old value 0.
//  3 p0 wr x7=0x1, p1 wr x7=0x2 same cycle -> x7=0x2; write x0=0xFF -> reads 0.
//  4 alloc x3 -> busy_o[3]=1 next cycle; wr x3 -> busy_o[3]=0; alloc+wr x3 same
//    cycle -> busy_o[3]=1 and x3 holds written data.
//  5 alloc x1,x2,x4 over 3 cycles, then flush_i with alloc x9 -> busy_o all 0.
//  6 reset asserted while x6 busy and wr x6 pending -> x6=0, busy_o[6]=0.

Source files
------------

// File: rtl/sparrow_pkg.sv
// Shared types and sizing helpers for the sparrow register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sparrow_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a register count; never below 1 bit.
    function automatic int reg_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int REG_AW = reg_aw(NREGS_DEF);

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/sparrow_regfile_wsel.sv
// Write-port selector: reports whether any enabled write targets addr, with winning data.
// Latency: combinational.
// Backpressure: none; highest-index matching port wins.
module sparrow_regfile_wsel
    import sparrow_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = REG_AW,
    parameter int NWR  = 2
) (
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    // Ascending scan so a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (wr_addr[i] == addr)) begin
                hit  = 1'b1;
                data = wr_data[i];
            end
        end
    end

endmodule

// File: rtl/sparrow_regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and per-register busy scoreboard.
// Latency: writes/busy updates land on the next rising edge; reads are combinational.
// Backpressure: none; every enabled write and alloc is accepted in its cycle.
module sparrow_regfile_sb
    import sparrow_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = reg_aw(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
    output logic [NRD-1:0][XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]           rd_busy_o,
    input  logic [NWR-1:0]           wr_en_i,
    input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
    input  logic                     alloc_en_i,
    input  logic [AW-1:0]            alloc_addr_i,
    input  logic                     flush_i,
    output logic [NREGS-1:0]         busy_o
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    assign busy_o = busy;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign regs[r] = '0;
            assign busy[r] = 1'b0;
        end else begin : g_live
            localparam logic [AW-1:0] RA = AW'(r);
            logic            hit;
            logic [XLEN-1:0] wdat;
            logic [XLEN-1:0] q;
            logic            b;

            sparrow_regfile_wsel #(
                .XLEN (XLEN),
                .AW   (AW),
                .NWR  (NWR)
            ) u_wsel (
                .wr_en   (wr_en_i),
                .wr_addr (wr_addr_i),
                .wr_data (wr_data_i),
                .addr    (RA),
                .hit     (hit),
                .data    (wdat)
            );

            // Data register: capture the winning write; flush does not touch data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (hit) begin
                    q <= wdat;
                end
            end

            // Busy bit: flush beats alloc, alloc beats a same-cycle writeback.
            always_ff @(posedge clk) begin
                if (reset) begin
                    b <= 1'b0;
                end else if (flush_i) begin
                    b <= 1'b0;
                end else if (alloc_en_i && (alloc_addr_i == RA)) begin
                    b <= 1'b1;
                end else if (hit) begin
                    b <= 1'b0;
                end
            end

            assign regs[r] = q;
            assign busy[r] = b;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic zero_hit;

        // Register 0 must read as zero even when a write to it is in flight.
        assign zero_hit = (ZERO_REG != 0) && (rd_addr_i[p] == '0);

        if (BYPASS != 0) begin : g_byp
            logic            hit;
            logic [XLEN-1:0] dat;

            sparrow_regfile_wsel #(
                .XLEN (XLEN),
                .AW   (AW),
                .NWR  (NWR)
            ) u_byp (
                .wr_en   (wr_en_i),
                .wr_addr (wr_addr_i),
                .wr_data (wr_data_i),
                .addr    (rd_addr_i[p]),
                .hit     (hit),
                .data    (dat)
            );

            assign rd_data_o[p] = zero_hit ? '0 : (hit ? dat : regs[rd_addr_i[p]]);
        end else begin : g_nobyp
            assign rd_data_o[p] = zero_hit ? '0 : regs[rd_addr_i[p]];
        end

        // Busy is never bypassed: it always shows the registered scoreboard.
        assign rd_busy_o[p] = busy[rd_addr_i[p]];
    end

endmodule
